// File: rtl/datapath_gen.sv
// datapath_gen: multi-cycle RISC-V style datapath. It holds the instruction
// register, the register file, the PC / previous-PC registers, the ALU
// operand/result registers and a shifter that is either bit-serial or
// single-step.
//
// Parameters
//   XLEN       datapath width (32 or 64)
//   NREG       architectural register count (16 or 32)
//   INIT_ADDR  PC value on reset and on pc_sel = 01
//   SHIFT_ITER 1 = one bit per cycle shifter, 0 = whole shift in one step
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   *_we                     write enables for instr, regfile, pc, rs1/rs2,
//                            alu_reg and prev_pc
//   mem_ad_sel               memory address source: 0 pc, 1 alu_reg
//   a_sel, b_sel             ALU operand selects
//   pc_sel, wd_sel           PC input and regfile write-data selects
//   fmt                      immediate format (I, S, B, U, J)
//   alu_op                   ALU operation
//   sh_start, sh_op          shifter start and operation (SLL, SRL, SRA)
//   mem_rd                   memory read data
//   instr, rs2_reg, mem_ad   instruction register, store data, memory address
//   alu_flags                {V, C, N, Z} of the current ALU result
//   sh_busy, sh_done         shifter status
//   reg_illegal              a register field points beyond NREG
module datapath_gen #(
  parameter int              XLEN       = 32,
  parameter int              NREG       = 32,
  parameter logic [XLEN-1:0] INIT_ADDR  = '0,
  parameter int              SHIFT_ITER = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_we,
  input  logic            rf_we,
  input  logic            pc_we,
  input  logic            rs1_we,
  input  logic            rs2_we,
  input  logic            alu_we,
  input  logic            prev_pc_we,
  input  logic            mem_ad_sel,
  input  logic [1:0]      a_sel,
  input  logic [1:0]      b_sel,
  input  logic [1:0]      pc_sel,
  input  logic [2:0]      wd_sel,
  input  logic [2:0]      fmt,
  input  logic [3:0]      alu_op,
  input  logic            sh_start,
  input  logic [1:0]      sh_op,
  input  logic [XLEN-1:0] mem_rd,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] rs2_reg,
  output logic [XLEN-1:0] mem_ad,
  output logic [3:0]      alu_flags,
  output logic            sh_busy,
  output logic            sh_done,
  output logic            reg_illegal
);

  localparam int         SHW   = $clog2(XLEN);
  localparam int         RIDX  = $clog2(NREG);
  localparam logic [5:0] NREG6 = 6'(NREG);

  typedef enum logic [1:0] {
    SH_IDLE,
    SH_SHIFT,
    SH_DONE
  } shState_e;

  logic [31:0]     instr_q;
  logic [XLEN-1:0] rs1Reg_q, rs2Reg_q, aluReg_q, prevPc_q, pc_q;
  logic [XLEN-1:0] rf [NREG];

  shState_e        shState_q, shState_d;
  logic [XLEN-1:0] shVal_q, shVal_d;
  logic [SHW-1:0]  shCnt_q, shCnt_d;
  logic [1:0]      shOp_q, shOp_d;
  logic            shWrite;
  logic [XLEN-1:0] shResult, fullShift;
  logic [SHW-1:0]  shAmt;

  logic [4:0]      rs1Idx, rs2Idx, rdIdx;
  logic            rs1Ok, rs2Ok, rdOk;
  logic [XLEN-1:0] rs1Data, rs2Data, wdData;
  logic [XLEN-1:0] imm, aluA, aluB, aluC;
  logic [XLEN:0]   addSum, subSum;
  logic            carry, ovf;

  // Register file addressing. Indices at or above NREG behave like x0:
  // they read zero and swallow writes, and they raise reg_illegal.
  assign rs1Idx      = instr_q[19:15];
  assign rs2Idx      = instr_q[24:20];
  assign rdIdx       = instr_q[11:7];
  assign rs1Ok       = {1'b0, rs1Idx} < NREG6;
  assign rs2Ok       = {1'b0, rs2Idx} < NREG6;
  assign rdOk        = {1'b0, rdIdx} < NREG6;
  assign reg_illegal = ~(rs1Ok & rs2Ok & rdOk);
  assign rs1Data     = (rs1Ok && rs1Idx != 5'd0) ? rf[rs1Idx[RIDX-1:0]] : '0;
  assign rs2Data     = (rs2Ok && rs2Idx != 5'd0) ? rf[rs2Idx[RIDX-1:0]] : '0;

  // The regfile has no reset so its contents survive rst; rst still blocks
  // a write that happens to be enabled in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst && rf_we && rdOk && rdIdx != 5'd0) begin
      rf[rdIdx[RIDX-1:0]] <= wdData;
    end
  end

  // Immediate decode, sign-extended from instr[31] for every format.
  always_comb begin
    imm = '0;
    case (fmt)
      3'd0:    imm = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
      3'd1:    imm = {{(XLEN-12){instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      3'd2:    imm = {{(XLEN-13){instr_q[31]}}, instr_q[31], instr_q[7],
                      instr_q[30:25], instr_q[11:8], 1'b0};
      3'd3:    imm = {{(XLEN-32){instr_q[31]}}, instr_q[31:12], 12'b0};
      default: imm = {{(XLEN-21){instr_q[31]}}, instr_q[31], instr_q[19:12],
                      instr_q[20], instr_q[30:21], 1'b0};
    endcase
  end

  // ALU operand multiplexers.
  always_comb begin
    aluA = '0;
    case (a_sel)
      2'b00:   aluA = rs1Reg_q;
      2'b01:   aluA = pc_q;
      2'b10:   aluA = prevPc_q;
      default: aluA = '0;
    endcase
    aluB = {{(XLEN-3){1'b0}}, 3'd4};
    case (b_sel)
      2'b00:   aluB = rs2Reg_q;
      2'b01:   aluB = imm;
      default: aluB = {{(XLEN-3){1'b0}}, 3'd4};
    endcase
  end

  // Subtraction is a + ~b + 1 so that the carry-out reads as "no borrow".
  assign addSum = {1'b0, aluA} + {1'b0, aluB};
  assign subSum = {1'b0, aluA} + {1'b0, ~aluB} + {{XLEN{1'b0}}, 1'b1};

  // ALU result and carry/overflow; only ADD and SUB produce C and V.
  always_comb begin
    aluC  = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (alu_op)
      4'd0: begin
        aluC  = addSum[XLEN-1:0];
        carry = addSum[XLEN];
        ovf   = (aluA[XLEN-1] == aluB[XLEN-1]) && (addSum[XLEN-1] != aluA[XLEN-1]);
      end
      4'd1: begin
        aluC  = subSum[XLEN-1:0];
        carry = subSum[XLEN];
        ovf   = (aluA[XLEN-1] != aluB[XLEN-1]) && (subSum[XLEN-1] != aluA[XLEN-1]);
      end
      4'd2:    aluC = aluA & aluB;
      4'd3:    aluC = aluA | aluB;
      4'd4:    aluC = aluA ^ aluB;
      4'd5:    aluC = {{(XLEN-1){1'b0}}, $signed(aluA) < $signed(aluB)};
      4'd6:    aluC = {{(XLEN-1){1'b0}}, aluA < aluB};
      4'd7:    aluC = aluB;
      default: aluC = '0;
    endcase
  end

  assign alu_flags = {ovf, carry, aluC[XLEN-1], aluC == '0};

  // Regfile write data. The flag forms give SLT/SLTU-style results
  // straight from a SUB: N^V is "less than", ~C is "unsigned less than".
  always_comb begin
    wdData = '0;
    if (wd_sel[2]) begin
      wdData = wd_sel[0] ? {{(XLEN-1){1'b0}}, ~alu_flags[2]}
                         : {{(XLEN-1){1'b0}}, alu_flags[3] ^ alu_flags[1]};
    end else begin
      case (wd_sel[1:0])
        2'b00:   wdData = aluC;
        2'b01:   wdData = mem_rd;
        2'b10:   wdData = aluReg_q;
        default: wdData = pc_q;
      endcase
    end
  end

  function automatic logic [XLEN-1:0] shiftOne(input logic [XLEN-1:0] v,
                                               input logic [1:0]      op);
    if (op == 2'b00)      return {v[XLEN-2:0], 1'b0};
    else if (op == 2'b01) return {1'b0, v[XLEN-1:1]};
    else                  return {v[XLEN-1], v[XLEN-1:1]};
  endfunction

  assign shAmt = aluB[SHW-1:0];

  // Single-step shift result, used only when SHIFT_ITER is 0.
  always_comb begin
    fullShift = '0;
    case (sh_op)
      2'b00:   fullShift = aluA << shAmt;
      2'b01:   fullShift = aluA >> shAmt;
      default: fullShift = $signed(aluA) >>> shAmt;
    endcase
  end

  // Shifter next-state logic. Operand, amount and op are captured at the
  // start edge, so the ALU selects are free to change while shifting.
  // sh_start is only looked at in IDLE and DONE, which makes it ignored
  // while busy.
  always_comb begin
    shState_d = shState_q;
    shVal_d   = shVal_q;
    shCnt_d   = shCnt_q;
    shOp_d    = shOp_q;
    shWrite   = 1'b0;
    shResult  = shVal_q;
    case (shState_q)
      SH_SHIFT: begin
        if (shCnt_q != '0) begin
          shVal_d = shiftOne(shVal_q, shOp_q);
          shCnt_d = shCnt_q - SHW'(1);
        end else begin
          shWrite   = 1'b1;
          shResult  = shVal_q;
          shState_d = SH_DONE;
        end
      end
      default: begin
        if (shState_q == SH_DONE) shState_d = SH_IDLE;
        if (sh_start) begin
          shOp_d = sh_op;
          if (SHIFT_ITER != 0) begin
            shVal_d   = aluA;
            shCnt_d   = shAmt;
            shState_d = SH_SHIFT;
          end else begin
            shWrite   = 1'b1;
            shResult  = fullShift;
            shState_d = SH_DONE;
          end
        end
      end
    endcase
  end

  // Shifter state register; reset drops any shift in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      shState_q <= SH_IDLE;
      shVal_q   <= '0;
      shCnt_q   <= '0;
      shOp_q    <= 2'b00;
    end else begin
      shState_q <= shState_d;
      shVal_q   <= shVal_d;
      shCnt_q   <= shCnt_d;
      shOp_q    <= shOp_d;
    end
  end

  assign sh_busy = (shState_q == SH_SHIFT);
  assign sh_done = (shState_q == SH_DONE);

  // Architectural registers. A shifter result beats a same-cycle alu_we.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= INIT_ADDR;
      instr_q  <= '0;
      rs1Reg_q <= '0;
      rs2Reg_q <= '0;
      aluReg_q <= '0;
      prevPc_q <= '0;
    end else begin
      if (instr_we)   instr_q  <= mem_rd[31:0];
      if (rs1_we)     rs1Reg_q <= rs1Data;
      if (rs2_we)     rs2Reg_q <= rs2Data;
      if (prev_pc_we) prevPc_q <= pc_q;
      if (pc_we) begin
        case (pc_sel)
          2'b00:   pc_q <= aluC;
          2'b01:   pc_q <= INIT_ADDR;
          default: pc_q <= aluReg_q;
        endcase
      end
      if (shWrite)     aluReg_q <= shResult;
      else if (alu_we) aluReg_q <= aluC;
    end
  end

  assign instr   = instr_q;
  assign rs2_reg = rs2Reg_q;
  assign mem_ad  = mem_ad_sel ? aluReg_q : pc_q;

endmodule

// File: tb/tb_datapath_gen.sv
// Testbench for datapath_gen. Two instances share one set of stimulus:
// dutA is 32 registers with the bit-serial shifter, dutB is 16 registers
// with the single-step shifter, each with its own INIT_ADDR.
module tb_datapath_gen;

  localparam logic [31:0] INIT_A = 32'h0000_1000;
  localparam logic [31:0] INIT_B = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_we, rf_we, pc_we, rs1_we, rs2_we, alu_we, prev_pc_we;
  logic        mem_ad_sel, sh_start;
  logic [1:0]  a_sel, b_sel, pc_sel, sh_op;
  logic [2:0]  wd_sel, fmt;
  logic [3:0]  alu_op;
  logic [31:0] mem_rd;

  logic [31:0] instrA, rs2RegA, memAdA, instrB, rs2RegB, memAdB;
  logic [3:0]  flagsA, flagsB;
  logic        busyA, doneA, illegalA, busyB, doneB, illegalB;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  datapath_gen #(.XLEN(32), .NREG(32), .INIT_ADDR(INIT_A), .SHIFT_ITER(1)) dutA (
    .clk(clk), .rst(rst), .instr_we(instr_we), .rf_we(rf_we), .pc_we(pc_we),
    .rs1_we(rs1_we), .rs2_we(rs2_we), .alu_we(alu_we), .prev_pc_we(prev_pc_we),
    .mem_ad_sel(mem_ad_sel), .a_sel(a_sel), .b_sel(b_sel), .pc_sel(pc_sel),
    .wd_sel(wd_sel), .fmt(fmt), .alu_op(alu_op), .sh_start(sh_start),
    .sh_op(sh_op), .mem_rd(mem_rd), .instr(instrA), .rs2_reg(rs2RegA),
    .mem_ad(memAdA), .alu_flags(flagsA), .sh_busy(busyA), .sh_done(doneA),
    .reg_illegal(illegalA)
  );

  datapath_gen #(.XLEN(32), .NREG(16), .INIT_ADDR(INIT_B), .SHIFT_ITER(0)) dutB (
    .clk(clk), .rst(rst), .instr_we(instr_we), .rf_we(rf_we), .pc_we(pc_we),
    .rs1_we(rs1_we), .rs2_we(rs2_we), .alu_we(alu_we), .prev_pc_we(prev_pc_we),
    .mem_ad_sel(mem_ad_sel), .a_sel(a_sel), .b_sel(b_sel), .pc_sel(pc_sel),
    .wd_sel(wd_sel), .fmt(fmt), .alu_op(alu_op), .sh_start(sh_start),
    .sh_op(sh_op), .mem_rd(mem_rd), .instr(instrB), .rs2_reg(rs2RegB),
    .mem_ad(memAdB), .alu_flags(flagsB), .sh_busy(busyB), .sh_done(doneB),
    .reg_illegal(illegalB)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] expC;
    logic [3:0]  expFlags;
    logic [3:0]  flagMask;
  } aluVec_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] amt;
    logic [31:0] expRes;
  } shVec_t;

  aluVec_t aluVecs[13];
  shVec_t  shVecs[6];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearCtrl();
    instr_we = 0; rf_we = 0; pc_we = 0; rs1_we = 0; rs2_we = 0;
    alu_we = 0; prev_pc_we = 0; mem_ad_sel = 0; sh_start = 0;
    a_sel = 0; b_sel = 0; pc_sel = 0; sh_op = 0; wd_sel = 0;
    fmt = 0; alu_op = 0; mem_rd = 0;
  endtask

  task automatic loadInstr(input logic [31:0] v);
    mem_rd = v; instr_we = 1;
    tick();
    instr_we = 0;
  endtask

  task automatic writeReg(input logic [4:0] rd, input logic [31:0] val);
    loadInstr({20'b0, rd, 7'b0});
    mem_rd = val; wd_sel = 3'b001; rf_we = 1;
    tick();
    rf_we = 0; wd_sel = 3'b000;
  endtask

  task automatic readRegs(input logic [4:0] r1, input logic [4:0] r2);
    loadInstr({7'b0, r2, r1, 15'b0});
    rs1_we = 1; rs2_we = 1;
    tick();
    rs1_we = 0; rs2_we = 0;
  endtask

  task automatic checkAluReg(input string name, input logic [31:0] expA,
                             input logic [31:0] expB);
    mem_ad_sel = 1; #1;
    checkOutput({name, "_aluregA"}, memAdA, expA);
    checkOutput({name, "_aluregB"}, memAdB, expB);
    mem_ad_sel = 0; #1;
  endtask

  task automatic applyStimulus(input aluVec_t v, input int idx);
    writeReg(5'd1, v.a);
    writeReg(5'd2, v.b);
    readRegs(5'd1, 5'd2);
    a_sel = 2'b00; b_sel = 2'b00; alu_op = v.op; #1;
    checkOutput($sformatf("alu%0d_flagsA", idx), {28'b0, flagsA & v.flagMask},
                {28'b0, v.expFlags & v.flagMask});
    checkOutput($sformatf("alu%0d_flagsB", idx), {28'b0, flagsB & v.flagMask},
                {28'b0, v.expFlags & v.flagMask});
    alu_we = 1;
    tick();
    alu_we = 0;
    checkAluReg($sformatf("alu%0d", idx), v.expC, v.expC);
  endtask

  task automatic runShift(input shVec_t v, input int idx);
    int cyc;
    int doneCycle;
    writeReg(5'd1, v.a);
    writeReg(5'd2, v.amt);
    readRegs(5'd1, 5'd2);
    a_sel = 2'b00; b_sel = 2'b00; sh_op = v.op; sh_start = 1;
    tick();
    sh_start = 0;
    checkOutput($sformatf("sh%0d_doneB_c1", idx), {31'b0, doneB}, 32'd1);
    cyc = 1;
    doneCycle = 0;
    while (cyc <= 40 && doneCycle == 0) begin
      if (doneA) doneCycle = cyc;
      else begin
        tick();
        cyc++;
      end
    end
    checkOutput($sformatf("sh%0d_doneCycleA", idx), doneCycle,
                (v.amt % 32) + 2);
    tick();
    checkOutput($sformatf("sh%0d_doneA_after", idx), {31'b0, doneA}, 32'd0);
    checkAluReg($sformatf("sh%0d", idx), v.expRes, v.expRes);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [2:0]  fmtList[6];
    logic [31:0] immExp[6];
    logic [31:0] shBusyExp, shDoneExp, altDoneExp;
    logic        sawActivity;

    aluVecs[0]  = '{32'h7FFF_FFFF, 32'h1,         4'd0, 32'h8000_0000, 4'b1010, 4'hF};
    aluVecs[1]  = '{32'h5,         32'h5,         4'd1, 32'h0,         4'b0101, 4'hF};
    aluVecs[2]  = '{32'h3,         32'h5,         4'd1, 32'hFFFF_FFFE, 4'b0010, 4'hF};
    aluVecs[3]  = '{32'hFFFF_FFFF, 32'h1,         4'd0, 32'h0,         4'b0101, 4'hF};
    aluVecs[4]  = '{32'h8000_0000, 32'h1,         4'd1, 32'h7FFF_FFFF, 4'b1100, 4'hF};
    aluVecs[5]  = '{32'h8000_0000, 32'h8000_0000, 4'd0, 32'h0,         4'b1101, 4'hF};
    aluVecs[6]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 4'd2, 32'hF000_F000, 4'b0010, 4'h3};
    aluVecs[7]  = '{32'h0F0F_0000, 32'h0000_00F0, 4'd3, 32'h0F0F_00F0, 4'b0000, 4'h3};
    aluVecs[8]  = '{32'hFFFF_0000, 32'h0F0F_0F0F, 4'd4, 32'hF0F0_0F0F, 4'b0010, 4'h3};
    aluVecs[9]  = '{32'hFFFF_FFFF, 32'h1,         4'd5, 32'h1,         4'b0000, 4'h3};
    aluVecs[10] = '{32'hFFFF_FFFF, 32'h1,         4'd6, 32'h0,         4'b0001, 4'h3};
    aluVecs[11] = '{32'h0000_0123, 32'h0000_ABCD, 4'd7, 32'h0000_ABCD, 4'b0000, 4'h3};
    aluVecs[12] = '{32'h0000_1234, 32'h0000_5678, 4'd9, 32'h0,         4'b0001, 4'h3};

    shVecs[0] = '{2'b00, 32'h0000_0081, 32'd3,  32'h0000_0408};
    shVecs[1] = '{2'b01, 32'h8000_0000, 32'd31, 32'h0000_0001};
    shVecs[2] = '{2'b01, 32'h8000_0000, 32'd0,  32'h8000_0000};
    shVecs[3] = '{2'b10, 32'h7FFF_0000, 32'd8,  32'h007F_FF00};
    shVecs[4] = '{2'b11, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF};
    shVecs[5] = '{2'b00, 32'h0000_0001, 32'd35, 32'h0000_0008};

    fmtList[0] = 3'd0; immExp[0] = 32'hFFFF_FFED;
    fmtList[1] = 3'd1; immExp[1] = 32'hFFFF_FFF5;
    fmtList[2] = 3'd2; immExp[2] = 32'hFFFF_FFF4;
    fmtList[3] = 3'd3; immExp[3] = 32'hFEDC_B000;
    fmtList[4] = 3'd4; immExp[4] = 32'hFFFC_BFEC;
    fmtList[5] = 3'd7; immExp[5] = 32'hFFFC_BFEC;

    // Reset state.
    clearCtrl();
    rst = 1;
    tick();
    rst = 0;
    #1;
    checkOutput("rst_pcA", memAdA, INIT_A);
    checkOutput("rst_pcB", memAdB, INIT_B);
    checkOutput("rst_instrA", instrA, 32'h0);
    checkOutput("rst_rs2A", rs2RegA, 32'h0);
    checkOutput("rst_shA", {30'b0, busyA, doneA}, 32'h0);
    checkOutput("rst_shB", {30'b0, busyB, doneB}, 32'h0);
    checkAluReg("rst", 32'h0, 32'h0);

    // ALU operations from the vector table.
    for (int i = 0; i < 13; i++) applyStimulus(aluVecs[i], i);

    // Immediate formats through zero + imm.
    loadInstr(32'hFEDC_BA98);
    checkOutput("imm_illegalA", {31'b0, illegalA}, 32'd0);
    checkOutput("imm_illegalB", {31'b0, illegalB}, 32'd1);
    a_sel = 2'b11; b_sel = 2'b01; alu_op = 4'd0;
    for (int i = 0; i < 6; i++) begin
      fmt = fmtList[i]; alu_we = 1;
      tick();
      alu_we = 0;
      checkAluReg($sformatf("imm%0d", i), immExp[i], immExp[i]);
    end
    clearCtrl();

    // x0 is hard-wired to zero.
    writeReg(5'd0, 32'h0000_DEAD);
    readRegs(5'd0, 5'd0);
    checkOutput("x0_A", rs2RegA, 32'h0);
    checkOutput("x0_B", rs2RegB, 32'h0);

    // Out-of-range register on the 16-entry file.
    writeReg(5'd1, 32'h0000_0055);
    loadInstr({20'b0, 5'd17, 7'b0});
    checkOutput("rd17_illegalA", {31'b0, illegalA}, 32'd0);
    checkOutput("rd17_illegalB", {31'b0, illegalB}, 32'd1);
    mem_rd = 32'h0000_1234; wd_sel = 3'b001; rf_we = 1;
    tick();
    rf_we = 0;
    readRegs(5'd1, 5'd17);
    checkOutput("x17_A", rs2RegA, 32'h0000_1234);
    checkOutput("x17_B", rs2RegB, 32'h0);
    readRegs(5'd0, 5'd1);
    checkOutput("x1_keptA", rs2RegA, 32'h0000_0055);
    checkOutput("x1_keptB", rs2RegB, 32'h0000_0055);
    checkOutput("legal_illegalB", {31'b0, illegalB}, 32'd0);
    loadInstr({12'b0, 5'd16, 15'b0});
    checkOutput("rs1_16_illegalB", {31'b0, illegalB}, 32'd1);

    // PC, prev_pc and the PC input mux.
    clearCtrl();
    a_sel = 2'b01; b_sel = 2'b10; alu_op = 4'd0;
    pc_we = 1; prev_pc_we = 1; pc_sel = 2'b00;
    tick();
    pc_we = 0; prev_pc_we = 0;
    checkOutput("pc_plus4A", memAdA, INIT_A + 32'd4);
    checkOutput("pc_plus4B", memAdB, INIT_B + 32'd4);
    a_sel = 2'b10; b_sel = 2'b11; alu_we = 1;
    tick();
    alu_we = 0;
    checkAluReg("prevpc", INIT_A + 32'd4, INIT_B + 32'd4);
    a_sel = 2'b11; b_sel = 2'b10; alu_we = 1;
    tick();
    alu_we = 0;
    a_sel = 2'b01; pc_sel = 2'b11; pc_we = 1;
    tick();
    pc_we = 0;
    checkOutput("pc_aluregA", memAdA, 32'd4);
    checkOutput("pc_aluregB", memAdB, 32'd4);
    pc_sel = 2'b01; pc_we = 1;
    tick();
    pc_we = 0;
    checkOutput("pc_initA", memAdA, INIT_A);
    checkOutput("pc_initB", memAdB, INIT_B);
    loadInstr({20'b0, 5'd6, 7'b0});
    wd_sel = 3'b011; rf_we = 1;
    tick();
    rf_we = 0;
    readRegs(5'd0, 5'd6);
    checkOutput("wd_pcA", rs2RegA, INIT_A);
    checkOutput("wd_pcB", rs2RegB, INIT_B);

    // Flag-derived write data: 3 - 5 gives N^V = 1 and ~C = 1.
    clearCtrl();
    writeReg(5'd1, 32'd3);
    writeReg(5'd2, 32'd5);
    writeReg(5'd5, 32'hFF);
    readRegs(5'd1, 5'd2);
    alu_op = 4'd1;
    loadInstr({20'b0, 5'd3, 7'b0});
    wd_sel = 3'b100; rf_we = 1;
    tick();
    rf_we = 0;
    loadInstr({20'b0, 5'd4, 7'b0});
    wd_sel = 3'b101; rf_we = 1;
    tick();
    rf_we = 0;
    readRegs(5'd2, 5'd1);
    loadInstr({20'b0, 5'd5, 7'b0});
    wd_sel = 3'b111; rf_we = 1;
    tick();
    rf_we = 0;
    readRegs(5'd0, 5'd3);
    checkOutput("wd_nvA", rs2RegA, 32'd1);
    readRegs(5'd0, 5'd4);
    checkOutput("wd_notcA", rs2RegA, 32'd1);
    readRegs(5'd0, 5'd5);
    checkOutput("wd_notc0A", rs2RegA, 32'd0);
    checkOutput("wd_notc0B", rs2RegB, 32'd0);
    clearCtrl();

    // SRA 0x80000000 by 4: restart attempt while busy and a same-cycle
    // alu_we at the shifter write-back edge.
    writeReg(5'd1, 32'h8000_0000);
    writeReg(5'd2, 32'd4);
    readRegs(5'd1, 5'd2);
    a_sel = 2'b00; b_sel = 2'b00; sh_op = 2'b10; alu_op = 4'd0;
    shBusyExp  = 32'b0011_1110;
    shDoneExp  = 32'b0100_0000;
    altDoneExp = 32'b0000_1010;
    sh_start = 1;
    tick();
    sh_start = 0;
    for (int c = 1; c <= 7; c++) begin
      checkOutput($sformatf("sra_busyA_c%0d", c), {31'b0, busyA}, {31'b0, shBusyExp[c]});
      checkOutput($sformatf("sra_doneA_c%0d", c), {31'b0, doneA}, {31'b0, shDoneExp[c]});
      checkOutput($sformatf("sra_doneB_c%0d", c), {31'b0, doneB}, {31'b0, altDoneExp[c]});
      if (c == 2) sh_start = 1;
      if (c == 5) begin
        a_sel = 2'b11; b_sel = 2'b10; alu_we = 1;
      end
      tick();
      sh_start = 0; alu_we = 0;
    end
    checkAluReg("sra", 32'hF800_0000, 32'd4);
    clearCtrl();

    // Shift table: latency on dutA and result on both.
    for (int i = 0; i < 6; i++) runShift(shVecs[i], i);
    clearCtrl();

    // Reset in the middle of a 10-bit shift, with enables held high.
    writeReg(5'd1, 32'h1234_5678);
    writeReg(5'd2, 32'd10);
    readRegs(5'd1, 5'd2);
    sh_op = 2'b00; sh_start = 1;
    tick();
    sh_start = 0;
    tick();
    rst = 1; pc_we = 1; alu_we = 1; a_sel = 2'b11; b_sel = 2'b10;
    tick();
    rst = 0; pc_we = 0; alu_we = 0;
    sawActivity = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (busyA || doneA || busyB || doneB) sawActivity = 1'b1;
      tick();
    end
    checkOutput("midrst_shifter_quiet", {31'b0, sawActivity}, 32'd0);
    checkOutput("midrst_pcA", memAdA, INIT_A);
    checkOutput("midrst_pcB", memAdB, INIT_B);
    checkAluReg("midrst", 32'h0, 32'h0);
    readRegs(5'd1, 5'd2);
    checkOutput("midrst_rf_keptA", rs2RegA, 32'd10);
    checkOutput("midrst_rf_keptB", rs2RegB, 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
